// File: rtl/sensor_link_scheduler.sv
// Arbitrates host commands and the continuous-sampling timer onto one
// DHT11 reader and one UART transmitter; each transaction sends 2 bytes.
module sensor_link_scheduler #(
  parameter int PERIOD_TICKS = 10000,
  parameter int SNS_TIMEOUT  = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_en,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_code,
  output logic       cmd_ready,
  output logic       sns_start,
  input  logic       sns_done,
  input  logic       sns_err,
  input  logic [7:0] sns_temp,
  input  logic [7:0] sns_hum,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic       cont_active,
  output logic       cont_sel
);

  localparam int PW = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1;
  localparam int TW = (SNS_TIMEOUT > 1) ? $clog2(SNS_TIMEOUT) : 1;
  localparam logic [PW-1:0] PER_LAST = PW'(PERIOD_TICKS - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(SNS_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, SNS_START, SNS_WAIT, TX0, TX0_WAIT, TX1, TX1_WAIT
  } state_t;

  typedef enum logic [1:0] {
    K_STAT, K_TEMP, K_HUM, K_CONT
  } kind_t;

  state_t        state;
  kind_t         kind;
  logic          cont_pending;
  logic [PW-1:0] per_cnt;
  logic [TW-1:0] to_cnt;
  logic [7:0]    rsp_code;
  logic [7:0]    rsp_data;
  logic          accept;
  logic          service;
  logic          use_hum;

  assign accept  = (state == IDLE) && cmd_ready && cmd_valid;
  assign service = (state == IDLE) && cmd_ready && !cmd_valid
                   && cont_pending;
  assign use_hum = (kind == K_HUM) || ((kind == K_CONT) && cont_sel);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      kind         <= K_STAT;
      cmd_ready    <= 1'b0;
      sns_start    <= 1'b0;
      tx_start     <= 1'b0;
      tx_data      <= 8'h00;
      cont_active  <= 1'b0;
      cont_sel     <= 1'b0;
      cont_pending <= 1'b0;
      per_cnt      <= '0;
      to_cnt       <= '0;
      rsp_code     <= 8'h00;
      rsp_data     <= 8'h00;
    end else begin
      sns_start <= 1'b0;
      tx_start  <= 1'b0;

      // FSM assignments below override the timer on the same cycle
      if (cont_active && tick_en) begin
        if (per_cnt == PER_LAST) begin
          per_cnt      <= '0;
          cont_pending <= 1'b1;
        end else begin
          per_cnt <= per_cnt + PW'(1);
        end
      end

      unique case (state)
        IDLE: begin
          if (accept) begin
            cmd_ready <= 1'b0;
            rsp_data  <= 8'h00;
            case (cmd_code)
              8'h00, 8'h01, 8'h02: begin
                kind      <= (cmd_code == 8'h00) ? K_STAT :
                             (cmd_code == 8'h01) ? K_TEMP : K_HUM;
                sns_start <= 1'b1;
                state     <= SNS_START;
              end
              8'h03, 8'h04: begin
                cont_active  <= 1'b1;
                cont_sel     <= cmd_code[2];
                per_cnt      <= '0;
                cont_pending <= 1'b0;
                kind         <= K_CONT;
                sns_start    <= 1'b1;
                state        <= SNS_START;
              end
              8'h05: begin
                state <= TX0;
                if (cont_active) begin
                  rsp_code     <= cont_sel ? 8'h0B : 8'h0A;
                  cont_active  <= 1'b0;
                  cont_pending <= 1'b0;
                  per_cnt      <= '0;
                end else begin
                  rsp_code <= 8'hFF;
                end
              end
              default: begin
                rsp_code <= 8'hFF;
                state    <= TX0;
              end
            endcase
          end else if (service) begin
            cont_pending <= 1'b0;
            kind         <= K_CONT;
            cmd_ready    <= 1'b0;
            sns_start    <= 1'b1;
            state        <= SNS_START;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        SNS_START: begin
          to_cnt <= '0;
          state  <= SNS_WAIT;
        end
        SNS_WAIT: begin
          if (sns_done) begin
            state <= TX0;
            if (sns_err) begin
              rsp_code <= 8'h1F;
              rsp_data <= 8'h00;
            end else if (kind == K_STAT) begin
              rsp_code <= 8'h07;
              rsp_data <= 8'h00;
            end else begin
              rsp_code <= use_hum ? 8'h08 : 8'h09;
              rsp_data <= use_hum ? sns_hum : sns_temp;
            end
          end else if (to_cnt == TO_LAST) begin
            rsp_code <= 8'h1F;
            rsp_data <= 8'h00;
            state    <= TX0;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        TX0: begin
          if (!tx_busy) begin
            tx_data  <= rsp_code;
            tx_start <= 1'b1;
            state    <= TX0_WAIT;
          end
        end
        TX0_WAIT: begin
          // tx_start is high only on the first cycle here; busy may lag it
          if (!tx_start && !tx_busy) state <= TX1;
        end
        TX1: begin
          if (!tx_busy) begin
            tx_data  <= rsp_data;
            tx_start <= 1'b1;
            state    <= TX1_WAIT;
          end
        end
        TX1_WAIT: begin
          if (!tx_start && !tx_busy) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sensor_link_scheduler.md
Name: sensor_link_scheduler

Overview:
- Shares one DHT11 reader and one UART transmitter between two requesters: host commands (decoded UART Rx bytes) and an internal continuous-sampling period timer.
- Sequences each transaction in order: start the sensor read, wait for it to finish or time out, then send a 2-byte response (code byte, then data byte).
- Sits between the Rx command decoder, the DHT11 reader and the Tx serializer.

Parameters:
- PERIOD_TICKS, 10000: number of tick_en pulses between continuous samples (10 s at a 1 kHz tick).
- SNS_TIMEOUT, 50000: clk cycles to wait for sns_done before the read is declared failed.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- tick_en  in  1  1-cycle time-base pulse
- cmd_valid  in  1  host command present
- cmd_code  in  8  host command byte
- cmd_ready  out  1  scheduler accepts a command this cycle
- sns_start  out  1  1-cycle pulse that starts a sensor read
- sns_done  in  1  1-cycle pulse, read finished
- sns_err  in  1  read failed; valid with sns_done
- sns_temp  in  8  temperature byte; valid with sns_done
- sns_hum  in  8  humidity byte; valid with sns_done
- tx_start  out  1  1-cycle pulse, send tx_data
- tx_data  out  8  byte to transmit; held until the byte completes
- tx_busy  in  1  transmitter busy
- cont_active  out  1  continuous mode enabled
- cont_sel  out  1  continuous quantity: 0 = temperature, 1 = humidity

Behaviour:
- Reset (rst=0, async): FSM goes to IDLE. cmd_ready, sns_start, tx_start, cont_active, cont_sel and cont_pending all 0. tx_data = 0x00. Period and timeout counters = 0. Reset mid-transaction aborts it silently; no response is sent.
- Command codes:
  - 0x00 status
  - 0x01 read temperature
  - 0x02 read humidity
  - 0x03 start continuous temperature
  - 0x04 start continuous humidity
  - 0x05 stop continuous
  - any other code: invalid
- Responses (code byte, data byte):
  - status OK: 0x07, 0x00
  - sensor error or timeout: 0x1F, 0x00
  - temperature: 0x09, temp
  - humidity: 0x08, hum
  - continuous temperature stopped: 0x0A, 0x00
  - continuous humidity stopped: 0x0B, 0x00
  - invalid command, or stop while inactive: 0xFF, 0x00
- FSM states: IDLE, SNS_START, SNS_WAIT, TX0, TX0_WAIT, TX1, TX1_WAIT.
- IDLE:
  - cmd_ready=1 only in IDLE. A command is accepted when cmd_valid & cmd_ready; cmd_code is latched that cycle.
  - Arbitration: an accepted command has priority over cont_pending. Pending is serviced only in an IDLE cycle with cmd_valid=0.
  - Invalid command or stop → TX0 directly.
  - Stop while active: clears cont_active, cont_pending and the period counter; response uses cont_sel.
  - Start (0x03/0x04): sets cont_active=1 and cont_sel, clears counter and pending, then does an immediate read. Start while already active overrides cont_sel.
  - Status, read, start, or serviced pending → SNS_START.
- SNS_START: sns_start=1 for exactly one cycle; timeout counter cleared; → SNS_WAIT.
- SNS_WAIT:
  - sns_done=1: latch result, → TX0.
  - timeout counter reaches SNS_TIMEOUT-1: result = error, → TX0. A late sns_done is ignored.
- Response data source: single reads return the byte matching the request; continuous samples and start commands return the byte selected by cont_sel.
- Transmit sequence:
  - TX0: wait for tx_busy=0, then tx_data=code and tx_start=1 for one cycle; → TX0_WAIT.
  - TX0_WAIT: ignore tx_busy on the first cycle, then wait for tx_busy=0; → TX1.
  - TX1/TX1_WAIT: same handshake with the data byte; → IDLE.
- Period timer:
  - Runs only while cont_active. Counts tick_en pulses in every FSM state.
  - At count PERIOD_TICKS-1 with tick_en=1: counter wraps to 0, cont_pending=1.
  - A second elapse while pending is already set is dropped; there is no queue.
  - Pending is cleared when its read is started.
- Sensor error in continuous mode: sends 0x1F, 0x00; cont_active stays 1.
- Simultaneous events:
  - cmd_valid and pending in the same IDLE cycle: the command is served first; pending is kept.
  - Stop accepted while pending is set: pending cleared, no sample sent.

Test Plan:
- Reset then cmd 0x01, sensor returns temp=0x19 → exactly one sns_start pulse; Tx bytes 0x09, 0x19; cmd_ready=0 during the transaction, then 1.
- cmd 0x00 with sns_err=1 → 0x1F, 0x00. cmd 0x00 with sns_done never asserted → after SNS_TIMEOUT cycles, 0x1F, 0x00.
- cmd 0x04 with PERIOD_TICKS=4, hum=0x32 → immediate 0x08, 0x32; then one 0x08, 0x32 every 4 ticks; cont_sel=1.
- Continuous active, cmd 0x01 in the same cycle the period elapses → temperature response first, then the continuous humidity sample.
- cmd 0x05 while active (sel=0) → 0x0A, 0x00; cont_active=0 and no further samples. cmd 0x05 again → 0xFF, 0x00. cmd 0x7E → 0xFF, 0x00.
- rst low during TX0_WAIT → all outputs 0 immediately; second byte never sent; after release, a new cmd 0x02 completes normally.
